// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per
// cycle, fixed XLEN+1 cycle latency from accept to the done strobe.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [REGW-1:0] rd_in,
  input  logic            abort,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [REGW-1:0] rd_out
);

  localparam int unsigned CNTW = $clog2(XLEN);
  localparam int unsigned PW   = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        fn_q, fn_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   mb_q, mb_d;
  logic [REGW-1:0]   rd_pend_q, rd_pend_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [REGW-1:0]   rd_q, rd_d;
  logic              done_q, done_d;

  logic              sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg_in;
  logic [PW-1:0]     acc_in;
  logic [XLEN-1:0]   mb_in;

  // Operand magnitudes and result sign captured at accept
  always_comb begin
    sa     = 1'b0;
    sb     = 1'b0;
    neg_in = 1'b0;
    if (funct3[2]) begin
      sa = ~funct3[0] & op_a[XLEN-1];
      sb = ~funct3[0] & op_b[XLEN-1];
    end else begin
      sa = (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10) & op_a[XLEN-1];
      sb = (funct3[1:0] == 2'b01) & op_b[XLEN-1];
    end
    mag_a = sa ? ('0 - op_a) : op_a;
    mag_b = sb ? ('0 - op_b) : op_b;
    if (!funct3[2])     neg_in = sa ^ sb;
    else if (funct3[1]) neg_in = sa;
    else                neg_in = (sa ^ sb) & (op_b != '0);
    // Multiply shifts the multiplier out of the low half; divide shifts the dividend in
    acc_in = funct3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
    mb_in  = funct3[2] ? mag_b : mag_a;
  end

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_top;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
  logic [PW-1:0]   step_acc;

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    div_top  = acc_q[PW-1:XLEN-1];
    div_ge   = div_top >= {1'b0, mb_q};
    div_diff = XLEN'(div_top - {1'b0, mb_q});
    step_acc = {mul_sum, acc_q[XLEN-1:1]};
    if (fn_q[2]) begin
      step_acc = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                        : {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] quot_s, rem_s, res_fin;

  always_comb begin
    prod_s = neg_q ? ('0 - acc_q) : acc_q;
    quot_s = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s  = neg_q ? ('0 - acc_q[PW-1:XLEN]) : acc_q[PW-1:XLEN];
    res_fin = prod_s[PW-1:XLEN];
    if (fn_q[2])                 res_fin = fn_q[1] ? rem_s : quot_s;
    else if (fn_q[1:0] == 2'b00) res_fin = prod_s[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fn_d      = fn_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    mb_d      = mb_q;
    rd_pend_d = rd_pend_q;
    result_d  = result_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          fn_d      = funct3;
          neg_d     = neg_in;
          acc_d     = acc_in;
          mb_d      = mb_in;
          rd_pend_d = rd_in;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(XLEN - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!abort) begin
          done_d   = 1'b1;
          result_d = res_fin;
          rd_d     = rd_pend_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      fn_q      <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      mb_q      <= '0;
      rd_pend_q <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fn_q      <= fn_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      mb_q      <= mb_d;
      rd_pend_q <= rd_pend_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule
